// File: rtl/cl_seq_unit.sv
// cl_seq_unit: registered WIDTH-bit logic/arithmetic cell with multi-cycle shifts.
// Ports:
//   clk, reset_n      - rising-edge clock, asynchronous active-low reset
//   start             - request, sampled only while idle
//   s[2:0]            - op: AND, OR, XOR, NOT, ADD, SUB, SHL, SHR
//   acc               - 1: operand A is the current out register instead of a
//   a, b[WIDTH-1:0]   - operands; for shifts b[SW-1:0] is the shift amount
//   out[WIDTH-1:0]    - registered result, held until the next completion
//   zero, carry       - registered flags, updated together with out
//   busy              - high while a multi-cycle shift is in progress
//   done              - one-cycle pulse when out/zero/carry update
module cl_seq_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       s,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_work, w_work_nxt;
  logic [SW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;   // 0: SHL, 1: SHR

  logic [WIDTH-1:0] w_opa;
  logic [SW-1:0]    w_k;
  logic             w_is_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_res_carry;
  logic [WIDTH-1:0] w_work_step;
  logic             w_step_bit;

  assign w_opa      = acc ? r_out : a;
  assign w_k        = b[SW-1:0];
  assign w_is_shift = (s[2:1] == 2'b11);
  assign w_sum      = {1'b0, w_opa} + {1'b0, b};
  // MSB of the extended difference is the unsigned borrow
  assign w_diff     = {1'b0, w_opa} - {1'b0, b};

  // Single-cycle result; shifts only reach here with k == 0
  always_comb begin
    w_res       = '0;
    w_res_carry = 1'b0;
    case (s)
      3'b000:  w_res = w_opa & b;
      3'b001:  w_res = w_opa | b;
      3'b010:  w_res = w_opa ^ b;
      3'b011:  w_res = ~w_opa;
      3'b100:  begin w_res = w_sum[WIDTH-1:0];  w_res_carry = w_sum[WIDTH];  end
      3'b101:  begin w_res = w_diff[WIDTH-1:0]; w_res_carry = w_diff[WIDTH]; end
      default: w_res = w_opa;
    endcase
  end

  // One-bit shift step of the work register
  always_comb begin
    if (r_dir) begin
      w_work_step = {1'b0, r_work[WIDTH-1:1]};
      w_step_bit  = r_work[0];
    end else begin
      w_work_step = {r_work[WIDTH-2:0], 1'b0};
      w_step_bit  = r_work[WIDTH-1];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_zero  <= w_zero_nxt;
      r_carry <= w_carry_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_zero_nxt  = r_zero;
    w_carry_nxt = r_carry;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_is_shift && (w_k != '0)) begin
            w_work_nxt  = w_opa;
            w_cnt_nxt   = w_k;
            w_dir_nxt   = s[0];
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_out_nxt   = w_res;
            w_zero_nxt  = (w_res == '0);
            w_carry_nxt = w_res_carry;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        w_work_nxt = w_work_step;
        w_cnt_nxt  = r_cnt - SW'(1);
        if (r_cnt == SW'(1)) begin
          w_out_nxt   = w_work_step;
          w_zero_nxt  = (w_work_step == '0);
          w_carry_nxt = w_step_bit;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign out   = r_out;
  assign zero  = r_zero;
  assign carry = r_carry;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_cl_seq_unit.sv
// Self-checking bench for cl_seq_unit (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences and randomized ops against a reference model.
module tb_cl_seq_unit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   s;
  logic         acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         zero;
  logic         carry;
  logic         busy;
  logic         done;

  int checks;
  int failures;
  logic [W-1:0] m_out;

  cl_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .s(s), .acc(acc),
    .a(a), .b(b), .out(out), .zero(zero), .carry(carry),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   s;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_out;
    logic         e_carry;
    int           e_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model from the operation definitions, using plain integer arithmetic
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] opa, input logic [W-1:0] opb,
                        output logic [W-1:0] r, output logic c);
    int x, y, k, t;
    x = int'(opa);
    y = int'(opb);
    k = y % W;
    t = 0;
    c = 1'b0;
    case (op)
      3'd0: t = x & y;
      3'd1: t = x | y;
      3'd2: t = x ^ y;
      3'd3: t = 255 - x;
      3'd4: begin t = (x + y) % 256; c = ((x + y) >= 256); end
      3'd5: begin t = (x - y + 256) % 256; c = (x < y); end
      3'd6: begin t = (x * (1 << k)) % 256; c = (k != 0) && (((x >> (W - k)) % 2) == 1); end
      default: begin t = x >> k; c = (k != 0) && (((x >> (k - 1)) % 2) == 1); end
    endcase
    r = W'(t);
  endtask

  // Issue one request, wait for done with a cycle budget, check result and timing
  task automatic run_op(input logic [2:0] s_i, input logic acc_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input logic [W-1:0] e_out, input logic e_c,
                        input int e_lat, input string tag);
    int lat;
    logic exp_busy, busy_bad;
    exp_busy = (s_i[2:1] == 2'b11) && (b_i[2:0] != 3'd0);
    busy_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; s = s_i; acc = acc_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat <= 40) begin
      if (busy !== exp_busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 40) begin
      chk({tag, " timeout"}, 32'(lat), 32'(e_lat));
    end else begin
      if (busy !== 1'b0) busy_bad = 1'b1;
      chk({tag, " latency"}, 32'(lat), 32'(e_lat));
      chk({tag, " out"}, 32'(out), 32'(e_out));
      chk({tag, " zero"}, 32'(zero), 32'(e_out == '0));
      chk({tag, " carry"}, 32'(carry), 32'(e_c));
      chk({tag, " busy"}, 32'(busy_bad), 32'd0);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
    end
    m_out = e_out;
  endtask

  initial begin
    logic [W-1:0] ra, rb, r_exp, opa;
    logic [2:0]   rs;
    logic         racc, rc;
    int           rlat, dones;

    checks = 0; failures = 0; m_out = '0;
    start = 1'b0; s = '0; acc = 1'b0; a = '0; b = '0;

    vecs[0]  = '{3'd0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1};
    vecs[1]  = '{3'd3, 1'b0, 8'hF0, 8'h00, 8'h0F, 1'b0, 1};
    vecs[2]  = '{3'd4, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1};
    vecs[3]  = '{3'd5, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b1, 1};
    vecs[4]  = '{3'd5, 1'b0, 8'h07, 8'h05, 8'h02, 1'b0, 1};
    vecs[5]  = '{3'd1, 1'b0, 8'h0C, 8'h30, 8'h3C, 1'b0, 1};
    vecs[6]  = '{3'd2, 1'b0, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1};
    vecs[7]  = '{3'd6, 1'b0, 8'h81, 8'h03, 8'h08, 1'b0, 4};
    vecs[8]  = '{3'd7, 1'b0, 8'h81, 8'h01, 8'h40, 1'b1, 2};
    vecs[9]  = '{3'd6, 1'b0, 8'h5A, 8'h00, 8'h5A, 1'b0, 1};
    vecs[10] = '{3'd4, 1'b0, 8'h10, 8'h05, 8'h15, 1'b0, 1};
    vecs[11] = '{3'd4, 1'b1, 8'hAA, 8'h05, 8'h1A, 1'b0, 1};
    vecs[12] = '{3'd6, 1'b1, 8'hAA, 8'h01, 8'h34, 1'b0, 2};

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", 32'(out), 32'd0);
    chk("reset zero", 32'(zero), 32'd1);
    chk("reset carry", 32'(carry), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].s, vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].e_out,
             vecs[i].e_carry, vecs[i].e_lat, $sformatf("vec%0d", i));

    // Start pulsed while busy is ignored; exactly one done results
    @(negedge clk);
    start = 1'b1; s = 3'd6; acc = 1'b0; a = 8'h81; b = 8'h03;
    @(negedge clk);
    s = 3'd4; a = 8'h11; b = 8'h22;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("busy_start dones", 32'(dones), 32'd1);
    chk("busy_start out", 32'(out), 32'h08);
    m_out = 8'h08;

    // Back-to-back single-cycle ops: done every cycle
    @(negedge clk);
    start = 1'b1; acc = 1'b0; s = 3'd0; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    chk("b2b done1", 32'(done), 32'd1);
    chk("b2b out1", 32'(out), 32'h30);
    s = 3'd4; a = 8'h01; b = 8'h02;
    @(negedge clk);
    chk("b2b done2", 32'(done), 32'd1);
    chk("b2b out2", 32'(out), 32'h03);
    s = 3'd3; a = 8'hFF;
    @(negedge clk);
    chk("b2b done3", 32'(done), 32'd1);
    chk("b2b out3", 32'(out), 32'h00);
    chk("b2b zero3", 32'(zero), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b done_end", 32'(done), 32'd0);

    // Put a nonzero result in out, then reset in the middle of a long shift
    run_op(3'd4, 1'b0, 8'h40, 8'h02, 8'h42, 1'b0, 1, "pre_reset");
    @(negedge clk);
    start = 1'b1; s = 3'd6; acc = 1'b0; a = 8'h01; b = 8'h07;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midshift busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst out", 32'(out), 32'd0);
    chk("midrst zero", 32'(zero), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_out = '0;
    // acc right after reset uses opA = 0
    run_op(3'd4, 1'b1, 8'hEE, 8'h03, 8'h03, 1'b0, 1, "post_rst_acc");
    run_op(3'd4, 1'b0, 8'h20, 8'h22, 8'h42, 1'b0, 1, "post_rst_add");

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rs   = 3'($urandom_range(0, 7));
      racc = 1'($urandom_range(0, 1));
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      opa  = racc ? m_out : ra;
      ref_op(rs, opa, rb, r_exp, rc);
      rlat = ((rs[2:1] == 2'b11) && (rb[2:0] != 3'd0)) ? int'(rb[2:0]) + 1 : 1;
      run_op(rs, racc, ra, rb, r_exp, rc, rlat, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
